// File: rtl/padd_sat_pipe.sv
// Two-stage packed-SIMD saturating add/subtract with valid/ready handshake and sticky lane status.
// Optional saturation-event counter enabled by defining PADD_SAT_CNT_EN.
module padd_sat_pipe #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LANE_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          a,
    input  logic [DATA_W-1:0]          b,
    input  logic [1:0]                 mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          res,
    output logic [DATA_W/LANE_W-1:0]   sat_lane,
    output logic [DATA_W/LANE_W-1:0]   sat_sticky,
    input  logic                       sat_clr
`ifdef PADD_SAT_CNT_EN
    ,
    output logic [15:0]                sat_cnt
`endif
);

    localparam int unsigned LANES = DATA_W / LANE_W;

    if (((DATA_W % LANE_W) != 0) || (LANE_W < 2)) begin : g_bad_params
        $error("padd_sat_pipe: DATA_W must be a multiple of LANE_W and LANE_W >= 2");
    end

    logic                s1_valid;
    logic [DATA_W-1:0]   s1_a;
    logic [DATA_W-1:0]   s1_b;
    logic [1:0]          s1_mode;
    logic                adv1;
    logic                adv2;
    logic                xfer;
    logic [DATA_W-1:0]   lane_res_c;
    logic [LANES-1:0]    lane_sat_c;

    // S2 drains when empty or consumed; S1 may refill whenever its contents can move on
    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;
    assign xfer     = out_valid && out_ready;

    // Stage 1: operand capture
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_mode  <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a    <= a;
                s1_b    <= b;
                s1_mode <= mode;
            end
        end
    end

    // Per-lane arithmetic at LANE_W+1 bits; mode[1] selects unsigned, mode[0] selects subtract
    always_comb begin
        logic [LANE_W-1:0] la;
        logic [LANE_W-1:0] lb;
        logic [LANE_W-1:0] satv;
        logic [LANE_W:0]   ea;
        logic [LANE_W:0]   eb;
        logic [LANE_W:0]   sum;
        logic              uns;
        logic              sub;
        logic              ovf;
        lane_res_c = '0;
        lane_sat_c = '0;
        uns        = s1_mode[1];
        sub        = s1_mode[0];
        for (int unsigned i = 0; i < LANES; i++) begin
            la  = s1_a[i*LANE_W +: LANE_W];
            lb  = s1_b[i*LANE_W +: LANE_W];
            ea  = {(uns ? 1'b0 : la[LANE_W-1]), la};
            eb  = {(uns ? 1'b0 : lb[LANE_W-1]), lb};
            sum = sub ? (ea - eb) : (ea + eb);
            if (uns) begin
                // top bit is carry on add, borrow on subtract
                ovf  = sum[LANE_W];
                satv = sub ? {LANE_W{1'b0}} : {LANE_W{1'b1}};
            end else begin
                ovf  = sum[LANE_W] ^ sum[LANE_W-1];
                satv = la[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}}
                                    : {1'b0, {(LANE_W-1){1'b1}}};
            end
            lane_res_c[i*LANE_W +: LANE_W] = ovf ? satv : sum[LANE_W-1:0];
            lane_sat_c[i]                  = ovf;
        end
    end

    // Stage 2: result register, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            res       <= '0;
            sat_lane  <= '0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                res      <= lane_res_c;
                sat_lane <= lane_sat_c;
            end
        end
    end

    // Sticky status: a clear coinciding with a transfer keeps the transferred flags
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_sticky <= '0;
        end else if (xfer) begin
            sat_sticky <= (sat_clr ? {LANES{1'b0}} : sat_sticky) | sat_lane;
        end else if (sat_clr) begin
            sat_sticky <= '0;
        end
    end

`ifdef PADD_SAT_CNT_EN
    // Count of transferred beats with any saturated lane, clamped at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt <= '0;
        end else if (xfer) begin
            if (sat_clr) begin
                sat_cnt <= 16'(|sat_lane);
            end else if ((|sat_lane) && (sat_cnt != 16'hFFFF)) begin
                sat_cnt <= sat_cnt + 16'd1;
            end
        end else if (sat_clr) begin
            sat_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_padd_sat_pipe.sv
// Scoreboard bench for padd_sat_pipe: directed vectors, backpressure, sticky, reset flush and random traffic.
module tb_padd_sat_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [1:0]  mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] res;
    logic [3:0]  sat_lane;
    logic [3:0]  sat_sticky;
    logic        sat_clr = 1'b0;

    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [15:0] a8 = '0;
    logic [15:0] b8 = '0;
    logic [1:0]  mode8 = '0;
    logic        out_valid8;
    logic [15:0] res8;
    logic [1:0]  sat_lane8;
    logic [1:0]  sat_sticky8;
`ifdef PADD_SAT_CNT_EN
    logic [15:0] sat_cnt;
    logic [15:0] sat_cnt8;
`endif

    always #5 clk = ~clk;

    padd_sat_pipe #(.DATA_W(16), .LANE_W(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .sat_lane(sat_lane), .sat_sticky(sat_sticky), .sat_clr(sat_clr)
`ifdef PADD_SAT_CNT_EN
        , .sat_cnt(sat_cnt)
`endif
    );

    padd_sat_pipe #(.DATA_W(16), .LANE_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .mode(mode8), .out_valid(out_valid8), .out_ready(1'b1),
        .res(res8), .sat_lane(sat_lane8), .sat_sticky(sat_sticky8), .sat_clr(1'b0)
`ifdef PADD_SAT_CNT_EN
        , .sat_cnt(sat_cnt8)
`endif
    );

    typedef struct {
        logic [15:0] res;
        logic [3:0]  sat;
        time         t;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  sticky_m = '0;
    int          cnt_m = 0;
    bit          rand_on = 1'b0;
    exp_t        e;
    logic        exp_ov;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each lane is an integer clamped to its signed or unsigned range
    function automatic void model(input logic [15:0] ia, input logic [15:0] ib, input logic [1:0] im,
                                  input int lw, output logic [15:0] r, output logic [3:0] s);
        int mask = (1 << lw) - 1;
        int lo, hi, x, y, v;
        r = '0;
        s = '0;
        for (int i = 0; i < 16 / lw; i++) begin
            x = (int'(ia) >> (i * lw)) & mask;
            y = (int'(ib) >> (i * lw)) & mask;
            if (!im[1]) begin
                lo = -(1 << (lw - 1));
                hi = (1 << (lw - 1)) - 1;
                if (x > hi) x -= (1 << lw);
                if (y > hi) y -= (1 << lw);
            end else begin
                lo = 0;
                hi = mask;
            end
            v = im[0] ? (x - y) : (x + y);
            if (v > hi) begin
                v = hi;
                s[i] = 1'b1;
            end else if (v < lo) begin
                v = lo;
                s[i] = 1'b1;
            end
            r = r | (16'(v & mask) << (i * lw));
        end
    endfunction

    // Drive one beat (left asserted on return so beats can go back-to-back); expectation queued on accept
    task automatic send_exp(input logic [15:0] ia, input logic [15:0] ib, input logic [1:0] im,
                            input logic [15:0] er, input logic [3:0] es);
        bit done = 1'b0;
        in_valid = 1'b1;
        a = ia;
        b = ib;
        mode = im;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (!rst && in_ready) begin
                @(posedge clk);
                q.push_back('{er, es, $time});
                done = 1'b1;
            end else begin
                @(posedge clk);
            end
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=no_accept required=accept at %0t", $time);
            in_valid = 1'b0;
        end
    endtask

    task automatic send(input logic [15:0] ia, input logic [15:0] ib, input logic [1:0] im);
        logic [15:0] r;
        logic [3:0]  s;
        model(ia, ib, im, 4, r, s);
        send_exp(ia, ib, im, r, s);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: checks handshake, result and status every cycle; pops on each transfer
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            sticky_m = '0;
            cnt_m = 0;
        end else begin
            exp_ov = (q.size() > 0) && (($time - q[0].t) > 10);
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
            chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
            chk("sat_sticky", 32'(sat_sticky), 32'(sticky_m));
`ifdef PADD_SAT_CNT_EN
            chk("sat_cnt", 32'(sat_cnt), 32'(cnt_m));
`endif
            if (out_valid && q.size() > 0) begin
                chk("res", 32'(res), 32'(q[0].res));
                chk("sat_lane", 32'(sat_lane), 32'(q[0].sat));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=res_%h required=no_output at %0t", res, $time);
                end else begin
                    e = q.pop_front();
                    sticky_m = (sat_clr ? 4'b0000 : sticky_m) | e.sat;
                    if (sat_clr) cnt_m = (|e.sat) ? 1 : 0;
                    else if ((|e.sat) && cnt_m < 65535) cnt_m++;
                end
            end else if (sat_clr) begin
                sticky_m = '0;
                cnt_m = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_res", 32'(res), 32'd0);
        chk("rst_sat_lane", 32'(sat_lane), 32'd0);
        chk("rst_sat_sticky", 32'(sat_sticky), 32'd0);

        // Signed add with overflow in the two upper lanes
        send_exp(16'h7831, 16'h1F21, 2'b00, 16'h7852, 4'b1100);
        idle(4);
        chk("sticky_after_t1", 32'(sat_sticky), 32'h0000_000C);

        // Clear on the same cycle the next beat transfers keeps the new flags
        send_exp(16'h0070, 16'h0010, 2'b00, 16'h0070, 4'b0010);
        in_valid = 1'b0;
        @(posedge clk);
        #1 sat_clr = 1'b1;
        @(posedge clk);
        #1 sat_clr = 1'b0;
        chk("sticky_clr_xfer", 32'(sat_sticky), 32'h0000_0002);
        sat_clr = 1'b1;
        @(posedge clk);
        #1 sat_clr = 1'b0;
        chk("sticky_clr_only", 32'(sat_sticky), 32'd0);

        // Mixed modes back-to-back without bubbles
        send_exp(16'hF0A5, 16'h1163, 2'b10, 16'hF1F8, 4'b1010);
        send_exp(16'h3000, 16'h4001, 2'b11, 16'h0000, 4'b1001);
        send_exp(16'h8700, 16'h1F10, 2'b01, 16'h87F0, 4'b1100);
        idle(5);

        // Backpressure: third beat waits until the consumer is ready again
        out_ready = 1'b0;
        send_exp(16'hF0A5, 16'h1163, 2'b10, 16'hF1F8, 4'b1010);
        send_exp(16'h3000, 16'h4001, 2'b11, 16'h0000, 4'b1001);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        fork
            send_exp(16'h8700, 16'h1F10, 2'b01, 16'h87F0, 4'b1100);
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(6);

        // Random traffic with random stalls and occasional clears
        rand_on = 1'b1;
        fork
            while (rand_on) begin
                @(posedge clk);
                #1;
                out_ready = ($urandom_range(0, 3) != 0);
                sat_clr   = ($urandom_range(0, 15) == 0);
            end
            begin
                for (int n = 0; n < 300; n++) begin
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                    else send(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
                end
                in_valid = 1'b0;
                rand_on = 1'b0;
            end
        join
        out_ready = 1'b1;
        sat_clr = 1'b0;
        idle(6);

        // Reset with both stages full: nothing in flight may emerge afterwards
        send_exp(16'h7831, 16'h1F21, 2'b00, 16'h7852, 4'b1100);
        idle(4);
        out_ready = 1'b0;
        send_exp(16'h7831, 16'h1F21, 2'b00, 16'h7852, 4'b1100);
        send_exp(16'h0070, 16'h0010, 2'b00, 16'h0070, 4'b0010);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_sat_sticky", 32'(sat_sticky), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        idle(6);

        // Two 8-bit lanes
        in_valid8 = 1'b1;
        a8 = 16'h7F01;
        b8 = 16'h0101;
        mode8 = 2'b00;
        @(posedge clk);
        #1 in_valid8 = 1'b0;
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 6 && !seen; k++) begin
                if (out_valid8) seen = 1'b1;
                else begin
                    @(posedge clk);
                    #1;
                end
            end
            chk("w8_out_valid", 32'(seen), 32'd1);
            chk("w8_res", 32'(res8), 32'h0000_7F02);
            chk("w8_sat_lane", 32'(sat_lane8), 32'd2);
        end
        @(posedge clk);
        #1;
        chk("w8_sat_sticky", 32'(sat_sticky8), 32'd2);
`ifdef PADD_SAT_CNT_EN
        chk("w8_sat_cnt", 32'(sat_cnt8), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
